// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial-in / byte-out bundle for the uart_rx receiver.
//
// Signals:
//   rx         serial line, idle high, 8N1, LSB first (driven by the line side)
//   data[7:0]  last good byte after offset removal (driven by the receiver)
//   valid      one-cycle pulse, data updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       receiver is inside a frame (any state but IDLE)
//
// Modports:
//   master  line side: drives rx, observes the receiver outputs
//   slave   receiver side: samples rx, drives the outputs
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with start-bit glitch rejection, frame error
// detection, break handling and an optional constant offset removed from
// every received byte.
//
// Parameters:
//   BAUD          serial bit rate in bit/s
//   F             clk frequency in Hz (F/BAUD must be at least 4)
//   ASCII_OFFSET  subtracted mod 256 from each good byte
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active high
//   bus  uart_rx_if.slave: rx in; data, valid, frame_err, busy out
module uart_rx #(
  parameter int BAUD         = 115200,
  parameter int F            = 50000000,
  parameter int ASCII_OFFSET = 0
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int CPB  = F / BAUD;
  localparam int HALF = CPB / 2;
  // Counter only ever has to hold CPB-1.
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [7:0]    OFFSET8       = 8'(ASCII_OFFSET);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: F/BAUD must be at least 4 clocks per bit");
    end
  endgenerate

  // Two-flop synchronizer; flops reset to the idle (high) line level so
  // leaving reset never looks like a start bit.
  logic [1:0] r_rx_sync;
  logic       w_rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync <= 2'b11;
    end else begin
      r_rx_sync <= {r_rx_sync[0], bus.rx};
    end
  end

  assign w_rx_s = r_rx_sync[1];

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  logic          w_bit_tick;
  logic          w_half_tick;
  logic          w_sample_bit;
  logic [7:0]    w_shift_next;

  assign w_bit_tick   = (r_cnt == CNT_BIT_LAST);
  assign w_half_tick  = (r_cnt == CNT_HALF_LAST);
  assign w_sample_bit = (r_state == S_DATA) && w_bit_tick;

  // Each shift-register bit loads only when its own index is sampled, so the
  // byte lands LSB first without a physical shift.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
      assign w_shift_next[gi] = (w_sample_bit && (r_idx == 3'(gi))) ? w_rx_s
                                                                    : r_shift[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end

        // Re-check the start bit at its middle; a high line here was a glitch.
        S_START: begin
          if (w_half_tick) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Output registers load on the sampling edge, so the pulse appears
        // in the cycle after the stop-bit decision.
        S_STOP: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift - OFFSET8;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Line held low after a bad stop bit: wait silently for idle.
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed, table-driven bench for uart_rx.
// Three receivers share clk/rst: A (F=1000, BAUD=100, offset 0),
// B (F=1000, BAUD=100, offset 48) and C (default parameters).
module tb_uart_rx;

  localparam int CPB_T = 10;
  localparam int LAT_T = 2 + 1 + 5 + 9 * 10;     // 98
  localparam int CPB_D = 434;
  localparam int LAT_D = 2 + 1 + 217 + 9 * 434;  // 4126

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if ifa ();
  uart_rx_if ifb ();
  uart_rx_if ifc ();

  uart_rx #(.BAUD(100), .F(1000), .ASCII_OFFSET(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  uart_rx #(.BAUD(100), .F(1000), .ASCII_OFFSET(48)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  uart_rx dut_c (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor: counts pulses per receiver and records protocol violations.
  int v_cnt [3] = '{0, 0, 0};
  int f_cnt [3] = '{0, 0, 0};
  int v_cyc [3] = '{0, 0, 0};
  int both_cnt = 0;
  int long_cnt = 0;
  logic [2:0] prev_v = 3'b000;
  logic [2:0] prev_f = 3'b000;

  always @(negedge clk) begin : mon
    logic [2:0] v;
    logic [2:0] f;
    v = {ifc.valid, ifb.valid, ifa.valid};
    f = {ifc.frame_err, ifb.frame_err, ifa.frame_err};
    for (int i = 0; i < 3; i++) begin
      if (v[i] === 1'b1) begin
        v_cnt[i] = v_cnt[i] + 1;
        v_cyc[i] = cyc;
      end
      if (f[i] === 1'b1) f_cnt[i] = f_cnt[i] + 1;
      if (v[i] === 1'b1 && f[i] === 1'b1) both_cnt = both_cnt + 1;
      if ((v[i] === 1'b1 && prev_v[i] === 1'b1) ||
          (f[i] === 1'b1 && prev_f[i] === 1'b1)) long_cnt = long_cnt + 1;
    end
    prev_v = v;
    prev_f = f;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic chk_near(input string name, input int got, input int exp);
    n_cmp++;
    if (got < exp - 1 || got > exp + 1) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +-1", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic wait_clk(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int w, input logic val);
    if (w == 0)      ifa.rx = val;
    else if (w == 1) ifb.rx = val;
    else             ifc.rx = val;
  endtask

  function automatic int rd_data(input int w);
    if (w == 0)      return int'(ifa.data);
    else if (w == 1) return int'(ifb.data);
    else             return int'(ifc.data);
  endfunction

  function automatic int rd_busy(input int w);
    if (w == 0)      return int'(ifa.busy);
    else if (w == 1) return int'(ifb.busy);
    else             return int'(ifc.busy);
  endfunction

  function automatic int rd_valid(input int w);
    if (w == 0)      return int'(ifa.valid);
    else if (w == 1) return int'(ifb.valid);
    else             return int'(ifc.valid);
  endfunction

  function automatic int rd_ferr(input int w);
    if (w == 0)      return int'(ifa.frame_err);
    else if (w == 1) return int'(ifb.frame_err);
    else             return int'(ifc.frame_err);
  endfunction

  // Start bit, 8 data bits LSB first, stop bit; each held cpb clocks.
  task automatic send_frame(input int w, input logic [7:0] b, input logic stop,
                            input int cpb);
    drive(w, 1'b0);
    wait_clk(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(w, b[i]);
      wait_clk(cpb);
    end
    drive(w, stop);
    wait_clk(cpb);
  endtask

  typedef struct {
    int         w;
    logic [7:0] b;
    logic       stop;
    int         hold_low;
    int         idle;
    logic [7:0] exp_data;
    int         exp_v;
    int         exp_f;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int w;
    int v0;
    int f0;
    int t0;

    //             w  byte   stop  hold idle  data   v  f
    vecs[0] = '{0, 8'h35, 1'b1, 0,  20, 8'h35, 1, 0};
    vecs[1] = '{1, 8'h37, 1'b1, 0,  0,  8'h07, 1, 0};  // back-to-back pair
    vecs[2] = '{1, 8'h30, 1'b1, 0,  20, 8'h00, 1, 0};
    vecs[3] = '{1, 8'h20, 1'b1, 0,  20, 8'hF0, 1, 0};  // wraps below zero
    vecs[4] = '{0, 8'hA5, 1'b0, 50, 20, 8'h35, 0, 1};  // bad stop, then break
    vecs[5] = '{0, 8'h5A, 1'b1, 0,  20, 8'h5A, 1, 0};
    vecs[6] = '{0, 8'h00, 1'b1, 0,  20, 8'h00, 1, 0};
    vecs[7] = '{0, 8'hFF, 1'b1, 0,  20, 8'hFF, 1, 0};
    vecs[8] = '{1, 8'h00, 1'b1, 0,  20, 8'hD0, 1, 0};

    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    ifc.rx = 1'b1;
    rst    = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset dut%0d data", i),      rd_data(i),  0);
      chk($sformatf("reset dut%0d valid", i),     rd_valid(i), 0);
      chk($sformatf("reset dut%0d frame_err", i), rd_ferr(i),  0);
      chk($sformatf("reset dut%0d busy", i),      rd_busy(i),  0);
    end
    rst = 1'b0;
    wait_clk(5);

    for (int i = 0; i < NV; i++) begin
      w  = vecs[i].w;
      v0 = v_cnt[w];
      f0 = f_cnt[w];
      t0 = cyc;
      send_frame(w, vecs[i].b, vecs[i].stop, CPB_T);
      wait_clk(vecs[i].hold_low);
      drive(w, 1'b1);
      wait_clk(vecs[i].idle);
      chk($sformatf("vec%0d data", i), rd_data(w), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d valid pulses", i), v_cnt[w] - v0, vecs[i].exp_v);
      chk($sformatf("vec%0d frame_err pulses", i), f_cnt[w] - f0, vecs[i].exp_f);
      if (vecs[i].idle > 0)
        chk($sformatf("vec%0d busy after", i), rd_busy(w), 0);
      if (vecs[i].exp_v == 1)
        chk_near($sformatf("vec%0d valid latency", i), v_cyc[0 + w] - t0, LAT_T);
    end

    // Short low glitch: START is entered, then abandoned at mid-bit.
    v0 = v_cnt[0];
    f0 = f_cnt[0];
    drive(0, 1'b0);
    wait_clk(3);
    drive(0, 1'b1);
    wait_clk(1);
    chk("glitch busy in START", rd_busy(0), 1);
    wait_clk(30);
    chk("glitch busy after", rd_busy(0), 0);
    chk("glitch valid pulses", v_cnt[0] - v0, 0);
    chk("glitch frame_err pulses", f_cnt[0] - f0, 0);
    chk("glitch data held", rd_data(0), 8'hFF);

    // Reset for one clock during bit 4 of a frame whose tail is all ones.
    v0 = v_cnt[0];
    f0 = f_cnt[0];
    fork
      send_frame(0, 8'hF0, 1'b1, CPB_T);
      begin
        wait_clk(55);
        rst = 1'b1;
        wait_clk(1);
        chk("midrst data", rd_data(0), 0);
        chk("midrst busy", rd_busy(0), 0);
        chk("midrst valid", rd_valid(0), 0);
        chk("midrst frame_err", rd_ferr(0), 0);
        rst = 1'b0;
      end
    join
    wait_clk(20);
    chk("midrst valid pulses", v_cnt[0] - v0, 0);
    chk("midrst frame_err pulses", f_cnt[0] - f0, 0);

    v0 = v_cnt[0];
    t0 = cyc;
    send_frame(0, 8'h81, 1'b1, CPB_T);
    wait_clk(20);
    chk("post-rst data", rd_data(0), 8'h81);
    chk("post-rst valid pulses", v_cnt[0] - v0, 1);
    chk_near("post-rst valid latency", v_cyc[0] - t0, LAT_T);

    // Default parameters: 434 clocks per bit.
    v0 = v_cnt[2];
    f0 = f_cnt[2];
    t0 = cyc;
    send_frame(2, 8'h55, 1'b1, CPB_D);
    wait_clk(20);
    chk("default data", rd_data(2), 8'h55);
    chk("default valid pulses", v_cnt[2] - v0, 1);
    chk("default frame_err pulses", f_cnt[2] - f0, 0);
    chk_near("default valid latency", v_cyc[2] - t0, LAT_D);

    chk("valid and frame_err together", both_cnt, 0);
    chk("pulses longer than one clk", long_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-002 Parameter F, default 50000000, clk frequency in Hz.
REQ-003 Parameter ASCII_OFFSET, default 0, value subtracted mod 256 from each received byte before output (48 undoes the transmitter's digit-to-ASCII mapping).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-007 data  output  8  last good byte, minus ASCII_OFFSET; held until the next good frame.
REQ-008 valid  output  1  one-cycle pulse, data updated this cycle.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only; rx_s flops reset to 1.
REQ-012 CPB SHALL equal F/BAUD (integer division); HALF SHALL equal CPB/2 (integer division); CPB >= 4 required, elaboration error otherwise.
REQ-013 Bit-timing counter SHALL be wide enough for CPB-1 and SHALL clear to 0 on every state entry.
REQ-014 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: rx_s==0 -> START.
REQ-016 START: when counter==HALF-1, sample rx_s; 0 -> DATA with bit index 0; 1 -> IDLE (glitch, no output pulse).
REQ-017 DATA: when counter==CPB-1, shift rx_s into shift register bit[index], LSB first; after index 7 -> STOP, else index+1.
REQ-018 STOP: when counter==CPB-1, sample rx_s; 1 -> register data, pulse valid on the following cycle, -> IDLE; 0 -> pulse frame_err on the following cycle, data unchanged, -> BREAK.
REQ-019 BREAK: remain until rx_s==1, then -> IDLE; no further frame_err while line stays low.
REQ-020 valid and frame_err SHALL never be high together and SHALL each be high for exactly one clk.
REQ-021 data SHALL equal (received_byte - ASCII_OFFSET) mod 256, 8-bit wrap.
REQ-022 Falling edge on rx_s in the cycle the machine returns to IDLE SHALL be detected on the next cycle; back-to-back frames with no idle gap SHALL be received without loss.
REQ-023 Latency: valid SHALL rise exactly 2 (sync) + 1 + HALF + 9*CPB clk edges after the rx falling edge, within +-1 clk.

Reset
REQ-024 While rst==1: state IDLE, counter 0, bit index 0, shift register 0, data 0x00, valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; a frame starting after rst deasserts SHALL be received normally.

Verification (bench F=1000, BAUD=100 -> CPB=10, HALF=5, unless stated)
REQ-026 Send 0x35 as 8N1 at 10 clk/bit, ASCII_OFFSET=0 -> one valid pulse, data=0x35, frame_err never high, busy low afterwards.
REQ-027 ASCII_OFFSET=48, send 0x37 then 0x30 back-to-back, no idle gap -> two valid pulses, data=0x07 then 0x00; send 0x20 -> data=0xF0 (wrap).
REQ-028 Pulse rx low for 3 clk only -> state returns to IDLE, no valid, no frame_err, data unchanged.
REQ-029 Send 0xA5 with stop bit low, hold rx low 50 clk, then release and send 0x5A -> exactly one frame_err pulse, data stays at the prior value, then valid with data=0x5A.
REQ-030 Assert rst for 1 clk during bit 4 of a frame -> all outputs 0, no pulse; subsequent 0x81 frame -> valid, data=0x81.
REQ-031 Default parameters (CPB=434), send 0x55 -> valid rises 2+1+217+3906 clk +-1 after the start edge, data=0x55.
